wptr_full: RTL and testbench
============================

Name: wptr_full

Overview:
Write-domain pointer and status stage of the async CDC FIFO. It owns the binary write counter and drives the registered Gray write pointer into the read-domain `sync` instance. It consumes the read pointer that the write-domain `sync` instance has brought across as Gray code. From these it produces the RAM write address and the full, level and overflow status flags.

Parameters:
addrsize, 4, RAM address width; depth = 2**addrsize; pointers are addrsize+1 bits (extra wrap bit)

Ports:
clk  input  1  write-domain clock
rst_n  input  1  asynchronous active-low reset
winc  input  1  write request from producer
wq2_rptr  input  addrsize+1  Gray read pointer, already 2-FF synchronised into clk domain
wovf_clr  input  1  clears sticky overflow flag
wptr  output  addrsize+1  registered Gray write pointer, to read-domain synchroniser
waddr  output  addrsize  RAM write address (binary counter LSBs)
wen  output  1  RAM write enable = winc & ~wfull (combinational)
wfull  output  1  registered full flag
wlevel  output  addrsize+1  registered occupancy estimate, 0..2**addrsize
wovf  output  1  sticky overflow: write attempted while full

Behaviour:
- Reset (rst_n low, async) forces:
  - wbin=0, wptr=0, waddr=0, wfull=0, wlevel=0, wovf=0.
  - Outputs hold these values until the first clk edge after release.
- Accept: write occurs on the edge where winc=1 and wfull=0.
  - wbinnext = wbin + 1, modulo 2**(addrsize+1).
  - Otherwise wbinnext = wbin.
- Gray code: wgraynext = (wbinnext>>1) ^ wbinnext.
  - wptr is a flop loaded from wgraynext; no combinational logic follows it.
  - wptr changes at most one bit per clk.
- waddr = wbin[addrsize-1:0]; it updates with wbin.
- Full condition:
  - wfull <= (wgraynext == {~wq2_rptr[addrsize:addrsize-1], wq2_rptr[addrsize-2:0]}).
  - wfull rises on the same edge that accepts the write filling the last entry.
  - wfull falls on the first edge after wq2_rptr advances.
- Level:
  - rbin_s = gray2bin(wq2_rptr).
  - wlevel <= wbinnext - rbin_s, modulo 2**(addrsize+1).
  - Pessimistic: it lags reads by the synchroniser latency and never under-reports occupancy.
- Overflow:
  - winc=1 while wfull=1: no pointer change, wen=0, wovf <= 1.
  - wovf is sticky until wovf_clr. If set and clr occur in the same cycle, set wins.
- Wrap-around: the counter wraps from 2**(addrsize+1)-1 to 0. Full and level stay correct across the wrap via the MSB inversion and modular subtraction.
- wq2_rptr is treated as glitch-free (one Gray bit change per read clock); the block does no further synchronisation.
- Reset mid-operation: all state is cleared immediately. The read side must be reset in the same reset event; no partial recovery.

Optional Feature:
Macro WPTR_ALMOST_FULL_EN.
- With it defined:
  - Adds input afull_thresh [addrsize:0] and output walmost_full.
  - walmost_full is registered: walmost_full <= (wbinnext - rbin_s) >= afull_thresh.
  - walmost_full resets to 0.
- Without it: neither port exists and no comparator logic is generated.

Decomposition:
- Shared package fifo_pkg holds:
  - the pointer-width function (addrsize+1);
  - bin2gray and gray2bin functions, also used by the read-side rptr_empty.
- One sub-module is natural: gray2bin, a combinational parameterised XOR-prefix decoder, instantiated on wq2_rptr.
- Counter, flags and level stay in wptr_full.

Test Plan:
- Reset: assert rst_n=0 mid-stream with winc=1 → wptr=0, waddr=0, wfull=0, wlevel=0, wovf=0 immediately, before any clk edge.
- Fill: wq2_rptr=0, 16 consecutive winc pulses (addrsize=4):
  - wptr sequence 00001,00011,00010,…;
  - wfull=1 after the 16th edge, wptr=11000, wlevel=16.
- Overflow: with wfull=1, winc=1 for 3 cycles → wptr stays 11000, wen=0, wovf=1. Then wovf_clr=1 with winc=1 in the same cycle → wovf stays 1.
- Drain release: from full, set wq2_rptr=gray(4)=00110 → next edge wfull=0, wlevel=12. The next write is accepted at waddr=0.
- Wrap: 40 writes, with wq2_rptr tracking wbin-2 through a model → wptr wraps through 0 once, wfull never asserts, wlevel=2 throughout steady state.
- With WPTR_ALMOST_FULL_EN and afull_thresh=14, wq2_rptr=0: walmost_full rises on the 14th write edge and falls when wq2_rptr advances to gray(1) with level 13.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read pointer stages.
// Gray conversions work on a 32-bit container; narrower pointers are zero-extended.
package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic int ptr_width(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer/status stage of the async FIFO: binary/Gray write pointer,
// full, level and sticky overflow. Define WPTR_ALMOST_FULL_EN for walmost_full.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int addrsize = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [addrsize:0]   wq2_rptr,
    input  logic                wovf_clr,
`ifdef WPTR_ALMOST_FULL_EN
    input  logic [addrsize:0]   afull_thresh,
    output logic                walmost_full,
`endif
    output logic [addrsize:0]   wptr,
    output logic [addrsize-1:0] waddr,
    output logic                wen,
    output logic                wfull,
    output logic [addrsize:0]   wlevel,
    output logic                wovf
);

    localparam int PTR_W = ptr_width(addrsize);

    logic [PTR_W-1:0] r_wbin;
    logic [PTR_W-1:0] r_wptr;
    logic             r_wfull;
    logic [PTR_W-1:0] r_wlevel;
    logic             r_wovf;

    logic             w_accept;
    logic [PTR_W-1:0] w_wbinnext;
    logic [PTR_W-1:0] w_wgraynext;
    logic [PTR_W-1:0] w_rbin_s;
    logic [PTR_W-1:0] w_full_match;
    logic [PTR_W-1:0] w_level_next;

    gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_dec (
        .i_gray (wq2_rptr),
        .o_bin  (w_rbin_s)
    );

    assign w_accept     = winc & ~r_wfull;
    assign w_wbinnext   = r_wbin + PTR_W'(w_accept);
    assign w_wgraynext  = (w_wbinnext >> 1) ^ w_wbinnext;
    // A full FIFO's Gray write pointer equals the read pointer with its top two bits inverted.
    assign w_full_match = {~wq2_rptr[addrsize:addrsize-1], wq2_rptr[addrsize-2:0]};
    assign w_level_next = w_wbinnext - w_rbin_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_wlevel <= '0;
            r_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbinnext;
            r_wptr   <= w_wgraynext;
            r_wfull  <= (w_wgraynext == w_full_match);
            r_wlevel <= w_level_next;
            if (winc && r_wfull) begin
                r_wovf <= 1'b1;
            end else if (wovf_clr) begin
                r_wovf <= 1'b0;
            end
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    logic r_walmost_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_walmost_full <= 1'b0;
        end else begin
            r_walmost_full <= (w_level_next >= afull_thresh);
        end
    end

    assign walmost_full = r_walmost_full;
`endif

    assign wptr   = r_wptr;
    assign waddr  = r_wbin[addrsize-1:0];
    assign wen    = w_accept;
    assign wfull  = r_wfull;
    assign wlevel = r_wlevel;
    assign wovf   = r_wovf;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (addrsize=4) against an occupancy-count model.
// Exercises walmost_full too when WPTR_ALMOST_FULL_EN is defined.
module tb_wptr_full;

    logic       clk;
    logic       rst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wovf_clr;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       wen;
    logic       wfull;
    logic [4:0] wlevel;
    logic       wovf;
`ifdef WPTR_ALMOST_FULL_EN
    logic [4:0] afull_thresh;
    logic       walmost_full;
`endif

    int vectors = 0;
    int errors  = 0;

    // Reference model: write count, read count and occupancy as plain integers.
    int m_wbin  = 0;
    int m_rbin  = 0;
    int m_level = 0;
    bit m_full  = 0;
    bit m_ovf   = 0;
    bit m_afull = 0;
    int m_thresh = 14;
    logic [4:0] prevWptr = '0;
    int zeroSeen = 0;

    wptr_full #(
        .addrsize (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
`ifdef WPTR_ALMOST_FULL_EN
        .afull_thresh (afull_thresh),
        .walmost_full (walmost_full),
`endif
        .wptr         (wptr),
        .waddr        (waddr),
        .wen          (wen),
        .wfull        (wfull),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] toGray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".wptr"},   32'(wptr),   32'(toGray(m_wbin)));
        check({tag, ".waddr"},  32'(waddr),  32'(m_wbin % 16));
        check({tag, ".wfull"},  32'(wfull),  32'(m_full));
        check({tag, ".wlevel"}, 32'(wlevel), 32'(m_level));
        check({tag, ".wovf"},   32'(wovf),   32'(m_ovf));
        check({tag, ".onebit"}, 32'($countones(wptr ^ prevWptr) <= 1), 32'd1);
`ifdef WPTR_ALMOST_FULL_EN
        check({tag, ".afull"},  32'(walmost_full), 32'(m_afull));
`endif
        prevWptr = wptr;
        if (wptr == 5'd0) zeroSeen++;
    endtask

    // Drive one write-clock cycle from a negedge, advance the model at the posedge,
    // then compare at the following negedge.
    task automatic applyStimulus(input string tag, input bit inc, input bit clr, input int rb);
        bit acc;
        winc     = inc;
        wovf_clr = clr;
        wq2_rptr = toGray(rb);
`ifdef WPTR_ALMOST_FULL_EN
        afull_thresh = 5'(m_thresh);
`endif
        #1;
        check({tag, ".wen"}, 32'(wen), 32'(inc && !m_full));
        @(posedge clk);
        acc = inc && !m_full;
        if (inc && m_full) m_ovf = 1;
        else if (clr)      m_ovf = 0;
        m_wbin  = (m_wbin + int'(acc)) % 32;
        m_rbin  = rb % 32;
        m_level = (m_wbin - m_rbin + 32) % 32;
        m_full  = (m_level == 16);
        m_afull = (m_level >= m_thresh);
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        m_wbin = 0; m_rbin = 0; m_level = 0; m_full = 0; m_ovf = 0; m_afull = 0;
        prevWptr = '0;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int occ;
        rst_n = 1'b0;
        winc = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
`ifdef WPTR_ALMOST_FULL_EN
        afull_thresh = 5'd14;
`endif
        @(negedge clk);
        doReset();

        // Fill sixteen entries with the reader idle
        for (int i = 1; i <= 16; i++) begin
            applyStimulus("fill", 1'b1, 1'b0, 0);
            if (i == 1) check("fill.g1", 32'(wptr), 32'b00001);
            if (i == 2) check("fill.g2", 32'(wptr), 32'b00011);
            if (i == 3) check("fill.g3", 32'(wptr), 32'b00010);
`ifdef WPTR_ALMOST_FULL_EN
            if (i == 13) check("afull.below", 32'(walmost_full), 32'd0);
            if (i == 14) check("afull.rise",  32'(walmost_full), 32'd1);
`endif
        end
        check("fill.full",  32'(wfull),  32'd1);
        check("fill.wptr",  32'(wptr),   32'b11000);
        check("fill.level", 32'(wlevel), 32'd16);

        // Writes while full are dropped and latch overflow
        for (int i = 0; i < 3; i++) applyStimulus("ovf", 1'b1, 1'b0, 0);
        check("ovf.wptr", 32'(wptr), 32'b11000);
        check("ovf.flag", 32'(wovf), 32'd1);
        applyStimulus("ovfclr.setwins", 1'b1, 1'b1, 0);
        check("ovfclr.setwins.flag", 32'(wovf), 32'd1);
        applyStimulus("ovfclr", 1'b0, 1'b1, 0);
        check("ovfclr.flag", 32'(wovf), 32'd0);

        // Reader has consumed four entries
        applyStimulus("drain", 1'b0, 1'b0, 4);
        check("drain.full",  32'(wfull),  32'd0);
        check("drain.level", 32'(wlevel), 32'd12);
        check("drain.waddr", 32'(waddr),  32'd0);
        applyStimulus("drain.write", 1'b1, 1'b0, 4);
        check("drain.waddr1", 32'(waddr), 32'd1);

        // Asynchronous reset in the middle of a cycle with a write pending
        winc = 1'b1;
        #2;
        doReset();

`ifdef WPTR_ALMOST_FULL_EN
        for (int i = 0; i < 14; i++) applyStimulus("afull.fill", 1'b1, 1'b0, 0);
        check("afull.at14", 32'(walmost_full), 32'd1);
        applyStimulus("afull.fall", 1'b0, 1'b0, 1);
        check("afull.fell", 32'(walmost_full), 32'd0);
        check("afull.lvl13", 32'(wlevel), 32'd13);
        doReset();
`endif

        // Wrap: reader trails the writer closely for 40 writes
        zeroSeen = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus("wrap", 1'b1, 1'b0, (i >= 1) ? (m_wbin + 31) % 32 : 0);
            if (i >= 1) check("wrap.level2", 32'(wlevel), 32'd2);
            check("wrap.nofull", 32'(wfull), 32'd0);
        end
        check("wrap.zero_once", 32'(zeroSeen), 32'd1);

        // Randomized traffic: reader may only consume entries already written
        m_thresh = $urandom_range(0, 16);
        for (int i = 0; i < 400; i++) begin
            int rb;
            rb = m_rbin;
            occ = (m_wbin - m_rbin + 32) % 32;
            if (occ > 0 && $urandom_range(0, 2) == 0) rb = (m_rbin + 1) % 32;
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
